imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
// - Hardware instruction loader for the single-cycle CPU; the producer side of instruction-memory initialisation.
// - Receives instruction words as a byte stream over a valid/ready handshake and writes them into u_Instruction_Memory.
// - Holds the CPU in reset until an all-zero terminator word arrives. The all-zero word is also the CPU's end-of-program marker.
// PARAMETERS
// - DEPTH   256  instruction memory depth in 32-bit words
// - ADDR_W  8    word-address width, clog2(DEPTH)
// PORTS
// - clk_i         in   1       single clock, rising edge
// - rst_i         in   1       asynchronous, active-high reset
// - byte_valid_i  in   1       source presents byte_data_i
// - byte_data_i   in   8       stream byte; each word is little-endian, first byte = bits[7:0]
// - byte_ready_o  out  1       loader accepts a byte when valid & ready at the clock edge
// - imem_we_o     out  1       instruction memory write strobe, one word per cycle
// - imem_addr_o   out  ADDR_W  word address (byte address >> 2)
// - imem_wdata_o  out  32      write data
// - cpu_hold_o    out  1       1 = keep CPU in reset; 0 = CPU may run
// - done_o        out  1       load completed successfully
// - err_o         out  1       load failed (overflow or checksum mismatch)
// - word_count_o  out  ADDR_W+1  words written so far; the terminator is not counted
// BEHAVIOUR
// - Reset values: state=CLEAR, byte_ready_o=0, imem_we_o=0, imem_addr_o=0, imem_wdata_o=0, cpu_hold_o=1, done_o=0, err_o=0, word_count_o=0. The byte index and the assembly register are both 0.
// - States: CLEAR -> LOAD -> [CHECK] -> RUN. Any state may go to ERROR. RUN and ERROR exit only by reset.
// - CLEAR
//   - For DEPTH cycles: imem_we_o=1, imem_wdata_o=0, imem_addr_o counts 0..DEPTH-1.
//   - byte_ready_o=0 throughout.
//   - The cycle after addr DEPTH-1 is written, go to LOAD.
// - LOAD
//   - byte_ready_o=1.
//   - On each accepted byte, place it at byte index k: bits[8k+7:8k], k=0..3. Then advance k, wrapping 3 -> 0.
//   - The 4th byte completes a word. The action is registered and happens on the next cycle:
//     - Nonzero word and word_count_o<DEPTH: imem_we_o=1 for one cycle, imem_addr_o=word_count_o, imem_wdata_o=word; then word_count_o+1.
//     - Nonzero word and word_count_o==DEPTH: no write; go to ERROR.
//     - Zero word (terminator): no write, because memory is already cleared; go to RUN, or to CHECK if the checksum feature is compiled in.
//   - Byte acceptance continues during the write cycle. The write data is held in the output register, so there are no stall bubbles.
//   - Bytes with byte_valid_i=0 are ignored; idle gaps of any length are legal.
// - RUN: cpu_hold_o=0, done_o=1, byte_ready_o=0, imem_we_o=0. Further bytes are not accepted.
// - ERROR: err_o=1, cpu_hold_o=1, byte_ready_o=0, imem_we_o=0.
// - Reset mid-operation
//   - All outputs return to their reset values immediately, asynchronously.
//   - Partially assembled bytes are discarded, word_count_o=0, and CLEAR restarts from address 0.
// - imem_we_o is never asserted outside CLEAR and LOAD write cycles.
// CONFIGURATION
// - IMEM_LOADER_CHECKSUM_EN defined:
//   - An 8-bit running sum (mod 256) covers every accepted byte, including the terminator bytes.
//   - After the terminator, the loader enters CHECK with byte_ready_o=1 and accepts one more byte.
//   - If that byte equals the sum, go to RUN; otherwise go to ERROR.
// - IMEM_LOADER_CHECKSUM_EN undefined: no CHECK state and no sum logic; the terminator goes directly to RUN.
// TESTING
// - Release reset -> 256 consecutive cycles with we=1, data=0, addr 0..255; then byte_ready_o=1 and cpu_hold_o=1.
// - Send bytes 93 00 50 00, then 00 00 00 00 -> one write at addr 0 with data 0x00500093, one cycle after the 4th byte; then done_o=1, cpu_hold_o=0, word_count_o=1.
// - Repeat the previous case with random valid gaps of 0..5 cycles between bytes -> identical writes and final state.
// - Send 256 nonzero words, then a 257th nonzero word -> no 257th write, err_o=1, cpu_hold_o=1. A zero 257th word instead -> done_o=1.
// - Send 93 00, then pulse rst_i -> outputs return to reset values; CLEAR restarts at addr 0; the next full word is written at addr 0.
// - With IMEM_LOADER_CHECKSUM_EN: send the first word, the terminator, then checksum 0xE3 -> RUN. Checksum 0x00 instead -> ERROR with err_o=1.

Source files
------------

// File: rtl/imem_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : imem_loader_if                                             |
// | Description : Bundle of the byte-stream handshake, instruction-memory    |
// |               write port and CPU-control/status signals of the           |
// |               instruction loader.                                        |
// |   byte_valid_i   source presents byte_data_i                             |
// |   byte_data_i    stream byte, little-endian within each word             |
// |   byte_ready_o   loader accepts a byte on valid & ready                  |
// |   imem_we_o      instruction memory write strobe                         |
// |   imem_addr_o    word address                                            |
// |   imem_wdata_o   write data                                              |
// |   cpu_hold_o     1 = keep CPU in reset                                   |
// |   done_o         load completed successfully                             |
// |   err_o          load failed (overflow or checksum mismatch)             |
// |   word_count_o   words written so far (terminator not counted)           |
// | Modports    : master = loader side, slave = stream source / memory side  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface imem_loader_if #(
   parameter int ADDR_W = 8
);
   logic              byte_valid_i;
   logic [7:0]        byte_data_i;
   logic              byte_ready_o;
   logic              imem_we_o;
   logic [ADDR_W-1:0] imem_addr_o;
   logic [31:0]       imem_wdata_o;
   logic              cpu_hold_o;
   logic              done_o;
   logic              err_o;
   logic [ADDR_W:0]   word_count_o;

   modport master (
      input  byte_valid_i, byte_data_i,
      output byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o,
             cpu_hold_o, done_o, err_o, word_count_o
   );

   modport slave (
      output byte_valid_i, byte_data_i,
      input  byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o,
             cpu_hold_o, done_o, err_o, word_count_o
   );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : imem_loader                                                |
// | Description : Instruction-memory loader for the single-cycle CPU.        |
// |               Clears the whole memory, then assembles little-endian      |
// |               32-bit words from a valid/ready byte stream and writes     |
// |               them from address 0 upward. An all-zero word terminates    |
// |               the load and releases the CPU from reset.                  |
// | Ports       : clk_i  - clock, rising edge                                |
// |               rst_i  - asynchronous active-high reset                    |
// |               bus    - imem_loader_if.master (stream, memory port,       |
// |                        cpu_hold/done/err status, word count)             |
// | Options     : IMEM_LOADER_CHECKSUM_EN - after the terminator, accept one |
// |               checksum byte that must equal the mod-256 sum of all       |
// |               stream bytes (terminator included).                        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module imem_loader #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input wire            clk_i,
   input wire            rst_i,
   imem_loader_if.master bus
);

   localparam logic [ADDR_W:0]   c_depth     = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

   typedef enum logic [2:0] {
      ST_CLEAR = 3'd0,
      ST_LOAD  = 3'd1,
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK = 3'd2,
`endif
      ST_RUN   = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_next;

   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [ADDR_W:0]   r_count;
   logic [1:0]        r_k;      // byte index within the word being assembled
   logic [23:0]       r_asm;    // bytes 0..2; byte 3 is taken straight from the stream

   logic              w_ready;
   logic              w_accept;
   logic              w_word_done;
   logic              w_wr;
   logic [31:0]       w_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        r_sum;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sum <= 8'd0;
      end else if (w_accept && (r_state == ST_LOAD)) begin
         r_sum <= r_sum + bus.byte_data_i;
      end
   end
`endif

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_CLEAR;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------
   // Next state and handshake decode
   // ------------------------------------------------------------------
   always_comb begin
      w_ready = (r_state == ST_LOAD);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (r_state == ST_CHECK) begin
         w_ready = 1'b1;
      end
`endif
      w_accept     = w_ready & bus.byte_valid_i;
      w_word       = {bus.byte_data_i, r_asm};
      w_word_done  = w_accept && (r_state == ST_LOAD) && (r_k == 2'd3);
      w_wr         = w_word_done && (w_word != 32'd0) && (r_count != c_depth);
      w_state_next = r_state;

      case (r_state)
         ST_CLEAR: begin
            // r_we marks that the sweep has started, so the wrap check
            // cannot fire on the idle first cycle after reset
            if (r_we && (r_addr == c_last_addr)) begin
               w_state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (w_word_done) begin
               if (w_word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  w_state_next = ST_CHECK;
`else
                  w_state_next = ST_RUN;
`endif
               end else if (r_count == c_depth) begin
                  w_state_next = ST_ERROR;
               end
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (w_accept) begin
               w_state_next = (bus.byte_data_i == r_sum) ? ST_RUN : ST_ERROR;
            end
         end
`endif
         ST_RUN:   w_state_next = ST_RUN;
         ST_ERROR: w_state_next = ST_ERROR;
         default:  w_state_next = ST_ERROR;
      endcase
   end

   // ------------------------------------------------------------------
   // Memory write port, word counter and word assembly
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= 32'd0;
         r_count <= '0;
         r_k     <= 2'd0;
         r_asm   <= 24'd0;
      end else begin
         if (r_state == ST_CLEAR) begin
            r_wdata <= 32'd0;
            if (!r_we) begin
               r_we   <= 1'b1;
               r_addr <= '0;
            end else if (r_addr == c_last_addr) begin
               r_we   <= 1'b0;
            end else begin
               r_addr <= r_addr + 1'b1;
            end
         end else begin
            // The completed word is latched here, so the next byte can be
            // accepted while the write is presented to memory.
            r_we <= w_wr;
            if (w_wr) begin
               r_addr  <= r_count[ADDR_W-1:0];
               r_wdata <= w_word;
               r_count <= r_count + 1'b1;
            end
         end

         if (w_accept && (r_state == ST_LOAD)) begin
            r_k <= r_k + 2'd1;
            case (r_k)
               2'd0:    r_asm[7:0]   <= bus.byte_data_i;
               2'd1:    r_asm[15:8]  <= bus.byte_data_i;
               2'd2:    r_asm[23:16] <= bus.byte_data_i;
               default: ;
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs; status decodes follow the asynchronously reset state
   // ------------------------------------------------------------------
   assign bus.byte_ready_o = w_ready;
   assign bus.imem_we_o    = r_we;
   assign bus.imem_addr_o  = r_addr;
   assign bus.imem_wdata_o = r_wdata;
   assign bus.word_count_o = r_count;
   assign bus.cpu_hold_o   = (r_state != ST_RUN);
   assign bus.done_o       = (r_state == ST_RUN);
   assign bus.err_o        = (r_state == ST_ERROR);

endmodule
`default_nettype wire
